// File: rtl/dotmatrix_scroller_if.sv
// Host-side bus of the dot-matrix scroller: column writes, run control and frame output.
interface dotmatrix_scroller_if #(
  parameter int ADDR_W = 6
);
  logic              col_wr_en;
  logic [ADDR_W-1:0] col_wr_addr;
  logic [7:0]        col_wr_data;
  logic [ADDR_W:0]   msg_len;
  logic              start;
  logic              stop;
  logic [127:0]      dotmatrix_reg;
  logic              busy;
  logic              frame_done;

  modport master (
    output col_wr_en, col_wr_addr, col_wr_data, msg_len, start, stop,
    input  dotmatrix_reg, busy, frame_done
  );

  modport slave (
    input  col_wr_en, col_wr_addr, col_wr_data, msg_len, start, stop,
    output dotmatrix_reg, busy, frame_done
  );
endinterface

// File: rtl/dotmatrix_scroller.sv
// Scrolling frame source: builds a 16-column window of the message into a shadow frame
// and commits it atomically to the scan driver once every STEP_CYCLES clocks.
module dotmatrix_scroller #(
  parameter int MSG_COLS    = 64,
  parameter int ADDR_W      = 6,
  parameter int STEP_CYCLES = 5000000
) (
  input logic                clk,
  input logic                rst_n,
  dotmatrix_scroller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUILD, COMMIT, WAIT} state_t;

  localparam int WCNT_W = $clog2(STEP_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [127:0]      shadow_q, shadow_d;
  logic [127:0]      frame_q, frame_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        buf_q [MSG_COLS];

  logic [7:0]        col_rd;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] offset_nx;
  logic              start_ok;
  logic              wr_ok;

  assign len_m1   = ADDR_W'(len_q - (ADDR_W+1)'(1));
  assign col_rd   = buf_q[ptr_q];
  assign start_ok = bus.start && (bus.msg_len != '0) &&
                    (bus.msg_len <= (ADDR_W+1)'(MSG_COLS));
  assign wr_ok    = (state_q == IDLE) && bus.col_wr_en &&
                    ({1'b0, bus.col_wr_addr} < (ADDR_W+1)'(MSG_COLS));

  assign bus.dotmatrix_reg = frame_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.frame_done    = frame_done_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    offset_d     = offset_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    shadow_d     = shadow_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    offset_nx    = (offset_q == len_m1) ? '0 : offset_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d    = bus.msg_len;
          offset_d = '0;
          ptr_d    = '0;
          cnt_d    = '0;
          state_d  = BUILD;
        end
      end
      BUILD: begin
        // One column per cycle; ptr walks the message circularly so short messages tile.
        for (int r = 0; r < 8; r++) shadow_d[{r[2:0], cnt_q}] = col_rd[r];
        ptr_d = (ptr_q == len_m1) ? '0 : ptr_q + ADDR_W'(1);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = COMMIT;
      end
      COMMIT: begin
        frame_d      = shadow_q;
        frame_done_d = 1'b1;
        wcnt_d       = WCNT_W'(STEP_CYCLES - 17);
        state_d      = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WCNT_W'(1)) begin
          offset_d = offset_nx;
          ptr_d    = offset_nx;
          cnt_d    = '0;
          state_d  = BUILD;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // stop overrides everything, including a commit scheduled for this edge.
    if (bus.stop) begin
      state_d      = IDLE;
      frame_d      = frame_q;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      offset_q     <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      shadow_q     <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      shadow_q     <= shadow_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_COLS; i++) buf_q[i] <= '0;
    end else if (wr_ok) begin
      buf_q[bus.col_wr_addr] <= bus.col_wr_data;
    end
  end

endmodule

// File: tb/tb_dotmatrix_scroller.sv
// Self-checking bench for dotmatrix_scroller with a frame scoreboard and a message mirror.
module tb_dotmatrix_scroller;
  localparam int MSG_COLS = 64;
  localparam int ADDR_W   = 6;
  localparam int STEP     = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dotmatrix_scroller_if #(.ADDR_W(ADDR_W)) bus ();

  dotmatrix_scroller #(
    .MSG_COLS(MSG_COLS), .ADDR_W(ADDR_W), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   mem [MSG_COLS];
  logic [127:0] exp_q [$];

  function automatic logic [127:0] model_frame(int off, int len);
    logic [127:0] f;
    logic [7:0]   col;
    f = '0;
    for (int c = 0; c < 16; c++) begin
      col = mem[(off + c) % len];
      for (int r = 0; r < 8; r++) f[r*16+c] = col[r];
    end
    return f;
  endfunction

  task automatic wr_col(input int addr, input logic [7:0] data, input bit accepted);
    @(negedge clk);
    bus.col_wr_en   = 1'b1;
    bus.col_wr_addr = ADDR_W'(addr);
    bus.col_wr_data = data;
    @(negedge clk);
    bus.col_wr_en = 1'b0;
    if (accepted) mem[addr] = data;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    bus.msg_len = (ADDR_W+1)'(len);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_frame(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int cyc; bit seen; logic [127:0] got, want;
    rst_n = 1'b0;
    bus.stop = 1'b0; bus.start = 1'b1; bus.msg_len = 7'd16;
    bus.col_wr_en = 1'b1; bus.col_wr_addr = 6'd3; bus.col_wr_data = 8'hFF;
    repeat (3) @(negedge clk);
    total++; if (bus.dotmatrix_reg !== '0) begin bad++; $display("FAIL reset_frame got=%h want=0", bus.dotmatrix_reg); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.frame_done); end
    bus.start = 1'b0; bus.col_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MSG_COLS; i++) mem[i] = 8'h00;
    exp_q.delete();
    do_start(16);
    exp_q.push_back(model_frame(0, 16));
    exp_q.push_back(model_frame(1, 16));
    for (int k = 0; k < 2; k++) begin
      wait_frame(cyc, seen);
      total++; if (!seen || cyc != ((k == 0) ? 17 : STEP)) begin bad++; $display("FAIL reset_timing k=%0d got=%0d seen=%0d want=%0d", k, cyc, seen, (k == 0) ? 17 : STEP); end
      got  = bus.dotmatrix_reg;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (got !== want) begin bad++; $display("FAIL reset_zero_frame k=%0d got=%h want=%h", k, got, want); end
    end
    do_stop();
  endtask

  task automatic test_static16();
    int cyc; bit seen; logic [127:0] got, want, ref_f;
    for (int i = 0; i < 16; i++) wr_col(i, 8'h01 << (i % 8), 1'b1);
    exp_q.delete();
    do_start(16);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL static_busy got=%b want=1", bus.busy); end
    exp_q.push_back(model_frame(0, 16));
    exp_q.push_back(model_frame(1, 16));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) ref_f[r*16+c] = ((c % 8) == r);
    for (int k = 0; k < 2; k++) begin
      wait_frame(cyc, seen);
      total++; if (!seen || cyc != ((k == 0) ? 17 : STEP)) begin bad++; $display("FAIL static_timing k=%0d got=%0d seen=%0d want=%0d", k, cyc, seen, (k == 0) ? 17 : STEP); end
      got  = bus.dotmatrix_reg;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (got !== want) begin bad++; $display("FAIL static_frame k=%0d got=%h want=%h", k, got, want); end
      if (k == 0) begin
        total++; if (got !== ref_f) begin bad++; $display("FAIL static_diag got=%h want=%h", got, ref_f); end
      end
    end
    do_stop();
  endtask

  task automatic test_wrap();
    int cyc; bit seen; logic [127:0] got, want; bit ones;
    for (int i = 0; i < 19; i++) wr_col(i, 8'h00, 1'b1);
    wr_col(19, 8'hFF, 1'b1);
    exp_q.delete();
    do_start(20);
    for (int k = 0; k <= 20; k++) exp_q.push_back(model_frame(k % 20, 20));
    for (int k = 0; k <= 20; k++) begin
      wait_frame(cyc, seen);
      total++; if (!seen || cyc != ((k == 0) ? 17 : STEP)) begin bad++; $display("FAIL wrap_timing k=%0d got=%0d seen=%0d", k, cyc, seen); end
      got  = bus.dotmatrix_reg;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (got !== want) begin bad++; $display("FAIL wrap_frame k=%0d got=%h want=%h", k, got, want); end
      if (k >= 4 && k <= 19) begin
        ones = 1'b1;
        for (int r = 0; r < 8; r++) ones &= got[r*16 + (19 - k)];
        total++; if (ones !== 1'b1) begin bad++; $display("FAIL wrap_column k=%0d got=%h want_col=%0d_all_ones", k, got, 19 - k); end
      end
    end
    do_stop();
  endtask

  task automatic test_short();
    int cyc; bit seen; logic [127:0] got, want;
    wr_col(0, 8'h81, 1'b1);
    wr_col(1, 8'h42, 1'b1);
    wr_col(2, 8'h24, 1'b1);
    exp_q.delete();
    do_start(3);
    exp_q.push_back(model_frame(0, 3));
    wait_frame(cyc, seen);
    total++; if (!seen || cyc != 17) begin bad++; $display("FAIL short_timing got=%0d seen=%0d want=17", cyc, seen); end
    got  = bus.dotmatrix_reg;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++; if (got !== want) begin bad++; $display("FAIL short_frame got=%h want=%h", got, want); end
    total++; if (got[15:0] !== 16'h9249) begin bad++; $display("FAIL short_row0 got=%h want=9249", got[15:0]); end
    do_stop();
  endtask

  task automatic test_stop();
    int cyc; bit seen; logic [127:0] got, want, last; int dones; bit busy_seen;
    exp_q.delete();
    do_start(16);
    exp_q.push_back(model_frame(0, 16));
    wait_frame(cyc, seen);
    got  = bus.dotmatrix_reg;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++; if (!seen || got !== want) begin bad++; $display("FAIL stop_first_frame got=%h want=%h seen=%0d", got, want, seen); end
    last = want;
    repeat (9) @(negedge clk);
    do_stop();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", bus.busy); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL stop_no_done got=%0d want=0", dones); end
    total++; if (bus.dotmatrix_reg !== last) begin bad++; $display("FAIL stop_hold got=%h want=%h", bus.dotmatrix_reg, last); end

    @(negedge clk);
    bus.msg_len = 7'd16; bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL startstop_busy got=%b want=0", bus.busy); end
    busy_seen = 1'b0; dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
      if (bus.frame_done === 1'b1) dones++;
    end
    total++; if (busy_seen || dones != 0) begin bad++; $display("FAIL startstop_idle got_busy=%0d got_done=%0d want=0", busy_seen, dones); end

    exp_q.delete();
    do_start(16);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", bus.busy); end
    exp_q.push_back(model_frame(0, 16));
    wait_frame(cyc, seen);
    total++; if (!seen || cyc != 17) begin bad++; $display("FAIL restart_timing got=%0d seen=%0d want=17", cyc, seen); end
    got  = bus.dotmatrix_reg;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++; if (got !== want) begin bad++; $display("FAIL restart_frame got=%h want=%h", got, want); end
    do_stop();
  endtask

  task automatic test_illegal();
    int cyc; bit seen; logic [127:0] got, want; bit busy_seen;
    int bad_lens [2] = '{0, 65};
    foreach (bad_lens[j]) begin
      do_start(bad_lens[j]);
      busy_seen = (bus.busy !== 1'b0);
      repeat (20) begin
        @(negedge clk);
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) busy_seen = 1'b1;
      end
      total++; if (busy_seen) begin bad++; $display("FAIL illegal_len len=%0d got_busy=1 want=0", bad_lens[j]); end
    end
    exp_q.delete();
    do_start(16);
    exp_q.push_back(model_frame(0, 16));
    exp_q.push_back(model_frame(1, 16));
    wr_col(5, 8'hAA, 1'b0);
    wr_col(1, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_frame(cyc, seen);
      got  = bus.dotmatrix_reg;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++; if (!seen || got !== want) begin bad++; $display("FAIL blocked_write k=%0d got=%h want=%h seen=%0d", k, got, want, seen); end
    end
    do_stop();
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; logic [127:0] got, want;
    exp_q.delete();
    do_start(16);
    wait_frame(cyc, seen);
    total++; if (!seen || bus.dotmatrix_reg === '0) begin bad++; $display("FAIL midreset_pre got=%h seen=%0d want=nonzero", bus.dotmatrix_reg, seen); end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.dotmatrix_reg !== '0) begin bad++; $display("FAIL midreset_frame got=%h want=0", bus.dotmatrix_reg); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MSG_COLS; i++) mem[i] = 8'h00;
    do_start(16);
    exp_q.push_back(model_frame(0, 16));
    wait_frame(cyc, seen);
    got  = bus.dotmatrix_reg;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++; if (!seen || got !== want) begin bad++; $display("FAIL midreset_buffer got=%h want=%h seen=%0d", got, want, seen); end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_static16();
    test_wrap();
    test_short();
    test_stop();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
